// File: rtl/dvp_capture_pkg.sv
// dvp_capture_pkg
// Shared types and helpers for the DVP capture front end.
//   state_e        : capture FSM states
//   fmt_e          : pixel conversion format, already decoded from fmt_sel
//   bytes_per_line : camera bytes in one well-formed line (two per pixel)
//   decode_fmt     : fmt_sel -> fmt_e, with 2'b11 aliased onto RGB565
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    S_WAIT_VS    = 2'b00,
    S_WAIT_START = 2'b01,
    S_ACTIVE     = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FMT_RGB565 = 2'b00,
    FMT_RGB444 = 2'b01,
    FMT_YUV_Y  = 2'b10
  } fmt_e;

  function automatic int bytes_per_line(input int h_active);
    return 2 * h_active;
  endfunction

  function automatic fmt_e decode_fmt(input logic [1:0] sel);
    case (sel)
      2'b01:   return FMT_RGB444;
      2'b10:   return FMT_YUV_Y;
      default: return FMT_RGB565;
    endcase
  endfunction

endpackage

// File: rtl/dvp_capture_win_if.sv
// dvp_capture_win_if
// Bundles the camera pin side (vsync, href, p_data) with the frame-buffer
// write side (pixel_data, mem_addr, pixel_valid) of the capture block.
//   master : camera model / environment (drives pins, observes writes)
//   slave  : dvp_capture_win (samples pins, drives writes)
interface dvp_capture_win_if #(
  parameter int OUT_W  = 12,
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [7:0]        p_data;
  logic [OUT_W-1:0]  pixel_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              pixel_valid;

  modport master (
    output vsync, href, p_data,
    input  pixel_data, mem_addr, pixel_valid
  );

  modport slave (
    input  vsync, href, p_data,
    output pixel_data, mem_addr, pixel_valid
  );
endinterface

// File: rtl/dvp_pixel_pack.sv
// dvp_pixel_pack
// Combinational byte-pair to pixel conversion.
//   hi    : first (phase 0) byte of the pair
//   lo    : second (phase 1) byte of the pair
//   fmt   : conversion format
//   pixel : 12-bit RGB444 / replicated gray, sized to OUT_W
module dvp_pixel_pack
  import dvp_capture_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic [7:0]       hi,
  input  logic [7:0]       lo,
  input  fmt_e             fmt,
  output logic [OUT_W-1:0] pixel
);

  logic [11:0] pix12;

  always_comb begin
    // RGB565 -> RGB444: keep top 4 bits of each channel; green straddles the pair
    pix12 = {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    case (fmt)
      FMT_RGB444: pix12 = {hi[3:0], lo[7:4], lo[3:0]};
      // Y sits in the high byte; the low byte is chroma and is dropped
      FMT_YUV_Y:  pix12 = {3{hi[7:4]}};
      default:    ;
    endcase
  end

  assign pixel = OUT_W'(pix12);

endmodule

// File: rtl/dvp_capture_win.sv
// dvp_capture_win
// DVP camera capture: frames byte pairs with vsync/href, converts them to a
// pixel word and issues dense frame-buffer writes, with optional 2:1
// decimation in both axes and sticky line/frame geometry error flags.
//   p_clock     : camera pixel clock (only clock)
//   reset       : asynchronous active-high reset
//   dvp         : camera pins in, frame-buffer write port out (slave modport)
//   fmt_sel     : conversion format, sampled at frame start
//   decim       : keep even-x/even-y pixels only, sampled at frame start
//   frame_done  : one-cycle pulse when a captured frame ends
//   line_err    : sticky, some line of this frame had a wrong byte count
//   frame_err   : sticky, last frame had a wrong line count
//   frame_cnt   : completed frames, wrapping
module dvp_capture_win
  import dvp_capture_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OUT_W    = 12,
  parameter int ADDR_W   = 19
) (
  input  logic               p_clock,
  input  logic               reset,
  dvp_capture_win_if.slave   dvp,
  input  logic [1:0]         fmt_sel,
  input  logic               decim,
  output logic               frame_done,
  output logic               line_err,
  output logic               frame_err,
  output logic [7:0]         frame_cnt
);

  // Counters saturate at all-ones, which is always beyond the legal range,
  // so runaway lines/frames still register as geometry errors.
  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 2);
  localparam int CW = ADDR_W + 1;

  localparam logic [XW:0]   BPL      = (XW + 1)'(bytes_per_line(H_ACTIVE));
  localparam logic [YW-1:0] Y_END    = YW'(V_ACTIVE);
  localparam logic [CW-1:0] LIM_FULL = CW'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CW-1:0] LIM_DEC  = CW'(((H_ACTIVE + 1) / 2) * ((V_ACTIVE + 1) / 2) - 1);

  state_e          state, state_nxt;
  logic            start_frame, end_frame;

  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            phase;
  logic            href_d;
  logic [CW-1:0]   addr_cnt;
  logic [7:0]      hi_byte;
  fmt_e            fmt_sh;
  logic            decim_sh;
  logic [OUT_W-1:0] pix_conv;

  logic            byte_en, pix_done, keep, room, strobe;
  logic            line_end, line_bad;
  logic [YW-1:0]   y_inc, y_end;

  // FSM state register
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) state <= S_WAIT_VS;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      S_WAIT_VS:    if (dvp.vsync) state_nxt = S_WAIT_START;
      S_WAIT_START: if (!dvp.vsync) begin
                      state_nxt   = S_ACTIVE;
                      start_frame = 1'b1;
                    end
      S_ACTIVE:     if (dvp.vsync) begin
                      state_nxt = S_WAIT_START;
                      end_frame = 1'b1;
                    end
      default:      state_nxt = S_WAIT_VS;
    endcase
  end

  // Bytes are only taken inside a frame; vsync rising wins over href.
  assign byte_en  = (state == S_ACTIVE) && !dvp.vsync && dvp.href;
  assign pix_done = byte_en && phase;
  assign keep     = !decim_sh || (!x[0] && !y[0]);
  assign room     = addr_cnt <= (decim_sh ? LIM_DEC : LIM_FULL);
  assign strobe   = pix_done && keep && room;

  // A line ends on href falling, or is cut short by vsync rising mid-line;
  // either way it is counted and its length checked.
  assign line_end = (state == S_ACTIVE) && href_d && (!dvp.href || dvp.vsync);
  assign line_bad = {x, phase} != BPL;
  assign y_inc    = (y == '1) ? y : y + 1'b1;
  assign y_end    = line_end ? y_inc : y;

  dvp_pixel_pack #(.OUT_W(OUT_W)) u_pack (
    .hi    (hi_byte),
    .lo    (dvp.p_data),
    .fmt   (fmt_sh),
    .pixel (pix_conv)
  );

  // High byte holding register; its content is meaningless until phase 1
  always_ff @(posedge p_clock) begin
    if (byte_en && !phase) hi_byte <= dvp.p_data;
  end

  // Capture stage: counters, flags and the registered write port
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      x               <= '0;
      y               <= '0;
      phase           <= 1'b0;
      href_d          <= 1'b0;
      addr_cnt        <= '0;
      fmt_sh          <= FMT_RGB565;
      decim_sh        <= 1'b0;
      dvp.pixel_valid <= 1'b0;
      dvp.pixel_data  <= '0;
      dvp.mem_addr    <= '0;
      frame_done      <= 1'b0;
      line_err        <= 1'b0;
      frame_err       <= 1'b0;
      frame_cnt       <= '0;
    end else begin
      dvp.pixel_valid <= 1'b0;
      frame_done      <= 1'b0;
      href_d          <= byte_en;

      if (start_frame) begin
        x         <= '0;
        y         <= '0;
        phase     <= 1'b0;
        addr_cnt  <= '0;
        line_err  <= 1'b0;
        frame_err <= 1'b0;
        fmt_sh    <= decode_fmt(fmt_sel);
        decim_sh  <= decim;
      end

      if (byte_en) begin
        phase <= ~phase;
        if (phase && (x != '1)) x <= x + 1'b1;
      end

      if (strobe) begin
        dvp.pixel_valid <= 1'b1;
        dvp.pixel_data  <= pix_conv;
        dvp.mem_addr    <= addr_cnt[ADDR_W-1:0];
        addr_cnt        <= addr_cnt + 1'b1;
      end

      // line_end never coincides with byte_en, so x/phase have one writer per cycle
      if (line_end) begin
        y     <= y_inc;
        x     <= '0;
        phase <= 1'b0;
        if (line_bad) line_err <= 1'b1;
      end

      if (end_frame) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
        if (y_end != Y_END) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture_win.sv
module tb_dvp_capture_win;

  localparam int H  = 4;
  localparam int VA = 2;
  localparam int VB = 4;
  localparam int OW = 12;
  localparam int AW = 4;

  logic       p_clock = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] fmt_sel = 2'b00;
  logic       decim   = 1'b0;

  logic       fd_a, le_a, fe_a, fd_b, le_b, fe_b;
  logic [7:0] fc_a, fc_b;

  dvp_capture_win_if #(.OUT_W(OW), .ADDR_W(AW)) ifa ();
  dvp_capture_win_if #(.OUT_W(OW), .ADDR_W(AW)) ifb ();

  assign ifb.vsync  = ifa.vsync;
  assign ifb.href   = ifa.href;
  assign ifb.p_data = ifa.p_data;

  dvp_capture_win #(.H_ACTIVE(H), .V_ACTIVE(VA), .OUT_W(OW), .ADDR_W(AW)) dut_a (
    .p_clock    (p_clock),
    .reset      (reset),
    .dvp        (ifa),
    .fmt_sel    (fmt_sel),
    .decim      (decim),
    .frame_done (fd_a),
    .line_err   (le_a),
    .frame_err  (fe_a),
    .frame_cnt  (fc_a)
  );

  dvp_capture_win #(.H_ACTIVE(H), .V_ACTIVE(VB), .OUT_W(OW), .ADDR_W(AW)) dut_b (
    .p_clock    (p_clock),
    .reset      (reset),
    .dvp        (ifb),
    .fmt_sel    (fmt_sel),
    .decim      (decim),
    .frame_done (fd_b),
    .line_err   (le_b),
    .frame_err  (fe_b),
    .frame_cnt  (fc_b)
  );

  always #5 p_clock = ~p_clock;

  // Write-port recorders
  logic [11:0] da [256];
  logic [3:0]  aa [256];
  logic [11:0] db [256];
  logic [3:0]  ab [256];
  int na = 0, nb = 0, fda = 0, fdb = 0;

  always @(negedge p_clock) begin
    if (ifa.pixel_valid) begin
      da[na & 255] = ifa.pixel_data;
      aa[na & 255] = ifa.mem_addr;
      na++;
    end
    if (ifb.pixel_valid) begin
      db[nb & 255] = ifb.pixel_data;
      ab[nb & 255] = ifb.mem_addr;
      nb++;
    end
    if (fd_a) fda++;
    if (fd_b) fdb++;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_fc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge p_clock);
    #1;
  endtask

  task automatic frame_begin();
    ifa.vsync = 1'b1;
    tick(); tick();
    ifa.vsync = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic frame_end();
    ifa.vsync = 1'b1;
    tick(); tick(); tick(); tick();
    exp_fc = (exp_fc + 1) & 255;
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] hi,
                           input logic [7:0] lo, input logic [7:0] stp);
    for (int b = 0; b < nbytes; b++) begin
      ifa.href   = 1'b1;
      ifa.p_data = (b % 2 == 0) ? hi : 8'(lo + stp * 8'(b / 2));
      tick();
    end
    ifa.href   = 1'b0;
    ifa.p_data = 8'h00;
    tick(); tick(); tick();
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(ifa.pixel_valid), 0);
    chk({tag, "_data"},  32'(ifa.pixel_data), 0);
    chk({tag, "_addr"},  32'(ifa.mem_addr), 0);
    chk({tag, "_done"},  32'(fd_a), 0);
    chk({tag, "_lerr"},  32'(le_a), 0);
    chk({tag, "_ferr"},  32'(fe_a), 0);
    chk({tag, "_fcnt"},  32'(fc_a), 0);
  endtask

  initial begin
    int base, fbase;

    vt[0] = '{2'b00, 8'hF8, 8'h1F, 12'hF0F};
    vt[1] = '{2'b11, 8'hF8, 8'h1F, 12'hF0F};
    vt[2] = '{2'b00, 8'h07, 8'hE0, 12'h0F0};
    vt[3] = '{2'b01, 8'h5A, 8'hC3, 12'hAC3};
    vt[4] = '{2'b01, 8'hFF, 8'h12, 12'hF12};
    vt[5] = '{2'b10, 8'hA0, 8'h55, 12'hAAA};
    vt[6] = '{2'b10, 8'h3C, 8'hFF, 12'h333};

    ifa.vsync  = 1'b1;
    ifa.href   = 1'b0;
    ifa.p_data = 8'h00;

    // Reset state
    tick(); tick();
    @(negedge p_clock);
    chk_outputs_zero("rst");
    tick();
    reset = 1'b0;
    tick();

    // Conversion table: two full lines of one byte pair per frame
    for (int i = 0; i < 7; i++) begin
      fmt_sel = vt[i].fmt;
      decim   = 1'b0;
      base    = na;
      fbase   = fda;
      frame_begin();
      send_line(2 * H, vt[i].hi, vt[i].lo, 8'd0);
      send_line(2 * H, vt[i].hi, vt[i].lo, 8'd0);
      frame_end();
      chk("tbl_cnt", 32'(na - base), 8);
      for (int k = 0; k < 8; k++) begin
        chk("tbl_data", 32'(da[(base + k) & 255]), 32'(vt[i].exp));
        chk("tbl_addr", 32'(aa[(base + k) & 255]), 32'(k));
      end
      chk("tbl_done", 32'(fda - fbase), 1);
      chk("tbl_lerr", 32'(le_a), 0);
      chk("tbl_ferr", 32'(fe_a), 0);
      chk("tbl_fcnt", 32'(fc_a), 32'(exp_fc));
    end

    // Format change mid-frame is ignored until the next frame
    fmt_sel = 2'b10;
    base    = na;
    frame_begin();
    send_line(2 * H, 8'hA0, 8'h55, 8'd0);
    fmt_sel = 2'b00;
    send_line(2 * H, 8'hA0, 8'h55, 8'd0);
    frame_end();
    chk("fmtlatch_cnt", 32'(na - base), 8);
    chk("fmtlatch_first", 32'(da[base & 255]), 32'h0AAA);
    chk("fmtlatch_last", 32'(da[(base + 7) & 255]), 32'h0AAA);
    base = na;
    frame_begin();
    send_line(2 * H, 8'hA0, 8'h55, 8'd0);
    send_line(2 * H, 8'hA0, 8'h55, 8'd0);
    frame_end();
    chk("fmtnext_first", 32'(da[base & 255]), 32'h0A0A);
    chk("fmtnext_last", 32'(da[(base + 7) & 255]), 32'h0A0A);

    // Decimation on the V=4 instance, pixel value encodes (y, x)
    fmt_sel = 2'b01;
    decim   = 1'b1;
    base    = nb;
    frame_begin();
    for (int yy = 0; yy < VB; yy++) send_line(2 * H, 8'(yy), 8'd0, 8'd1);
    frame_end();
    decim = 1'b0;
    chk("dec_cnt", 32'(nb - base), 4);
    chk("dec_d0", 32'(db[base & 255]), 32'h000);
    chk("dec_d1", 32'(db[(base + 1) & 255]), 32'h002);
    chk("dec_d2", 32'(db[(base + 2) & 255]), 32'h200);
    chk("dec_d3", 32'(db[(base + 3) & 255]), 32'h202);
    for (int k = 0; k < 4; k++) chk("dec_addr", 32'(ab[(base + k) & 255]), 32'(k));
    chk("dec_ferr", 32'(fe_b), 0);
    chk("dec_lerr", 32'(le_b), 0);

    // Odd byte count line
    fmt_sel = 2'b00;
    frame_begin();
    chk("short_lerr_pre", 32'(le_a), 0);
    base = na;
    send_line(7, 8'hF8, 8'h1F, 8'd0);
    chk("short_strobes", 32'(na - base), 3);
    chk("short_lerr", 32'(le_a), 1);
    send_line(2 * H, 8'hF8, 8'h1F, 8'd0);
    chk("short_total", 32'(na - base), 7);
    chk("short_last_addr", 32'(aa[(base + 6) & 255]), 6);
    frame_end();
    chk("short_ferr", 32'(fe_a), 0);
    chk("short_lerr_end", 32'(le_a), 1);
    frame_begin();
    chk("lerr_cleared", 32'(le_a), 0);
    send_line(2 * H, 8'hF8, 8'h1F, 8'd0);
    send_line(2 * H, 8'hF8, 8'h1F, 8'd0);
    frame_end();

    // Too many lines: saturated address, frame_err
    base  = na;
    fbase = fda;
    frame_begin();
    for (int l = 0; l < 3; l++) send_line(2 * H, 8'hF8, 8'h1F, 8'd0);
    frame_end();
    chk("long_cnt", 32'(na - base), 8);
    chk("long_last_addr", 32'(aa[(base + 7) & 255]), 7);
    chk("long_ferr", 32'(fe_a), 1);
    chk("long_lerr", 32'(le_a), 0);
    chk("long_done", 32'(fda - fbase), 1);
    chk("long_fcnt", 32'(fc_a), 32'(exp_fc));

    // Reset mid-line
    frame_begin();
    base  = na;
    fbase = fda;
    ifa.href = 1'b1;
    ifa.p_data = 8'hF8; tick();
    ifa.p_data = 8'h1F; tick();
    ifa.p_data = 8'hF8; tick();
    chk("prerst_strobe", 32'(na - base), 1);
    reset = 1'b1;
    ifa.p_data = 8'h1F;
    @(negedge p_clock);
    chk_outputs_zero("midrst");
    tick();
    reset  = 1'b0;
    exp_fc = 0;
    base   = na;
    for (int b = 0; b < 6; b++) begin
      ifa.p_data = (b % 2 == 0) ? 8'hF8 : 8'h1F;
      tick();
    end
    ifa.href = 1'b0;
    tick(); tick(); tick();
    chk("postrst_no_strobe", 32'(na - base), 0);
    chk("postrst_no_done", 32'(fda - fbase), 0);
    base = na;
    frame_begin();
    send_line(2 * H, 8'hF8, 8'h1F, 8'd0);
    send_line(2 * H, 8'hF8, 8'h1F, 8'd0);
    frame_end();
    chk("recover_cnt", 32'(na - base), 8);
    chk("recover_addr0", 32'(aa[base & 255]), 0);
    chk("recover_data", 32'(da[base & 255]), 32'h0F0F);
    chk("recover_fcnt", 32'(fc_a), 32'(exp_fc));
    chk("recover_ferr", 32'(fe_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
